// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
//
// Sends one command byte, such as LED set 0xED or reset 0xFF, to a PS/2 device.
// It drives the shared clock/data pair open-drain through active-high "pull low" enables.
// The transaction ends with either a device ACK or an error.
// A neighbouring receiver should ignore frames while busy is high.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset; releases both lines immediately
//   ps2_clk_in   raw PS/2 clock pin level (asynchronous)
//   ps2_data_in  raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   tx_data      byte to send
//   tx_valid     send request; accepted when tx_valid & tx_ready
//   tx_ready     high only while idle
//   busy         high from accept until return to idle
//   done         one-cycle pulse at the end of a transaction
//   ack_ok       device ACKed the last transaction (valid from done until next accept)
//   error        timeout or missing ACK on the last transaction (same validity)
module ps2_host_tx #(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned INH        = CYC_PER_US * INHIBIT_US;
    localparam int unsigned ST_TO      = CYC_PER_US * START_TIMEOUT_US;
    localparam int unsigned FR_TO      = CYC_PER_US * FRAME_TIMEOUT_US;
    localparam int unsigned MAX_A      = (INH > ST_TO) ? INH : ST_TO;
    localparam int unsigned MAX_CNT    = (MAX_A > FR_TO) ? MAX_A : FR_TO;
    localparam int unsigned CW         = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StWaitIdle,
        StFail
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [8:0]    shreg;     // {parity, data}; shifts right, refilled with 1s
    logic [3:0]    edge_cnt;  // falling edges seen since leaving RTS
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          clk_s;
    logic          data_s;
    logic          fe;
    logic          cnt_last;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign fe       = clk_prev & ~clk_s;
    // The counter is loaded with N and the state acts as it steps 1 -> 0,
    // so a load of N gives exactly N cycles in the state.
    assign cnt_last = (cnt == CW'(1));

    assign tx_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            cnt         <= '0;
            shreg       <= '0;
            edge_cnt    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            unique case (state)
                StIdle: begin
                    if (tx_valid) begin
                        shreg      <= {~^tx_data, tx_data};
                        ack_ok     <= 1'b0;
                        error      <= 1'b0;
                        cnt        <= CW'(INH);
                        ps2_clk_oe <= 1'b1;
                        state      <= StInhibit;
                    end
                end

                StInhibit: begin
                    if (cnt_last) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;  // start bit doubles as request-to-send
                        cnt         <= CW'(ST_TO);
                        edge_cnt    <= '0;
                        state       <= StRts;
                    end
                end

                StRts: begin
                    if (fe) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[8:1]};
                        cnt         <= CW'(FR_TO);
                        edge_cnt    <= 4'd1;
                        state       <= StSend;
                    end else if (cnt_last) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        ack_ok      <= 1'b0;
                        error       <= 1'b1;
                        done        <= 1'b1;
                        state       <= StFail;
                    end
                end

                StSend: begin
                    if (fe) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt == 4'd10) begin
                            // Eleventh edge: the device's ACK is on the data line.
                            ps2_data_oe <= 1'b0;
                            if (!data_s) begin
                                ack_ok <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                            cnt   <= CW'(FR_TO);
                            state <= StWaitIdle;
                        end else begin
                            // Edges 2..9 carry data then parity.
                            // By edge 10 the shifted-in 1 releases data for the stop bit.
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b1, shreg[8:1]};
                        end
                    end else if (cnt_last) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        ack_ok      <= 1'b0;
                        error       <= 1'b1;
                        done        <= 1'b1;
                        state       <= StFail;
                    end
                end

                StWaitIdle: begin
                    if (clk_s && data_s) begin
                        done  <= 1'b1;
                        state <= StIdle;
                    end else if (cnt_last) begin
                        done   <= 1'b1;
                        error  <= 1'b1;
                        ack_ok <= 1'b0;
                        state  <= StIdle;
                    end
                end

                StFail: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx.
// A behavioural PS/2 device shares the wired-AND bus with the DUT and clocks frames with a
// 40-cycle period.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    int         accepts = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ          (1_000_000),
        .INHIBIT_US      (100),
        .START_TIMEOUT_US(1500),
        .FRAME_TIMEOUT_US(2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .error      (error)
    );

    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            accepts <= accepts + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("accept_busy", busy, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < limit);
        check("done_seen", done, 1);
    endtask

    // Device side of one frame.
    // rx[i-1] is the line level sampled at rising edge i: bits 0-7, then parity, then stop.
    task automatic device(input int nedges, input bit ack, output logic [9:0] rx);
        int t;
        rx = '0;
        t  = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rts_seen", (t < 3000), 1);
        repeat (10) @(negedge clk);
        check("start_bit", ps2_data_in, 0);
        for (int i = 1; i <= nedges; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) rx[i-1] = ps2_data_in;
            check("ready_low", tx_ready, 0);
            if (i == 10 && ack) begin
                repeat (5) @(negedge clk);
                dev_data_low = 1'b1;
                repeat (15) @(negedge clk);
            end else if (i < nedges) begin
                repeat (20) @(negedge clk);
            end
        end
        if (nedges == 11 && ack) begin
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rx;
        int         n;
        int         t;
        int         base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_error", error, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // 1: 0xED with ACK
        send_req(8'hED);
        n = 1;
        do begin
            @(posedge clk);
            #1;
            if (ps2_clk_oe) n++;
        end while (ps2_clk_oe && n < 500);
        check("t1_inhibit_len", n, 100);
        check("t1_rts_data_oe", ps2_data_oe, 1);
        device(11, 1'b1, rx);
        check("t1_byte", rx[7:0], 8'hED);
        check("t1_parity", rx[8], 1);
        check("t1_stop", rx[9], 1);
        wait_done(200, n);
        check("t1_ack_ok", ack_ok, 1);
        check("t1_error", error, 0);

        // 2: 0xFF, no ACK
        send_req(8'hFF);
        device(11, 1'b0, rx);
        check("t2_byte", rx[7:0], 8'hFF);
        check("t2_parity", rx[8], 1);
        wait_done(200, n);
        check("t2_error", error, 1);
        check("t2_ack_ok", ack_ok, 0);
        check("t2_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // 3: device never clocks
        send_req(8'hED);
        t = 0;
        while (!ps2_data_oe && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("t3_rts", ps2_data_oe, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ps2_data_oe && n < 3000);
        check("t3_start_timeout", n, 1500);
        check("t3_done", done, 1);
        check("t3_error", error, 1);
        check("t3_ack_ok", ack_ok, 0);
        check("t3_clk_oe", ps2_clk_oe, 0);
        @(posedge clk);
        #1;
        check("t3_ready_next", tx_ready, 1);
        check("t3_done_pulse", done, 0);

        // 4: device stops after 5 edges
        send_req(8'hED);
        fork
            device(5, 1'b1, rx);
            begin
                t = 0;
                while (!ps2_data_oe && t < 500) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                while (ps2_data_oe && t < 1500) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("t4_bit0_driven", ps2_data_oe, 0);
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!done && n < 3000);
                check("t4_frame_timeout", n, 2000);
                check("t4_error", error, 1);
                check("t4_ack_ok", ack_ok, 0);
                check("t4_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check("t4_ready_in_fail", tx_ready, 0);
                @(posedge clk);
                #1;
                check("t4_ready_next", tx_ready, 1);
            end
        join

        // 5: reset in the middle of SEND
        send_req(8'hED);
        device(5, 1'b1, rx);
        check("t5_pre_reset_data_oe", ps2_data_oe, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t5_reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_ready", tx_ready, 1);
        check("t5_busy", busy, 0);
        send_req(8'h00);
        device(11, 1'b1, rx);
        check("t5_byte", rx[7:0], 8'h00);
        check("t5_parity", rx[8], 1);
        wait_done(200, n);
        check("t5_ack_ok", ack_ok, 1);

        // 6: tx_valid held across done
        base = accepts;
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy1", busy, 1);
        @(negedge clk);
        tx_data = 8'h00;  // must be ignored while busy
        device(11, 1'b1, rx);
        check("t6_byte1", rx[7:0], 8'hED);
        wait_done(200, n);
        check("t6_ack1", ack_ok, 1);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!busy && t < 20);
        check("t6_reaccept", busy, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        device(11, 1'b1, rx);
        check("t6_byte2", rx[7:0], 8'h00);
        wait_done(200, n);
        repeat (50) @(posedge clk);
        #1;
        check("t6_accepts", accepts - base, 2);
        check("t6_idle", tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
